// File: rtl/vending_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vending_fsm
// Description : Coin-operated vending controller. Accepts a product
//               selection, collects Rs5/Rs10 coins until the price is met,
//               then pulses dispense (with refund if change is due). Cancel
//               returns any credit collected so far.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_fsm #(
  parameter int PRICE_1  = 15,
  parameter int PRICE_2  = 20,
  parameter int PRICE_3  = 25,
  parameter int CREDIT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       cancel,
  input  logic [1:0] select,
  output logic       dispense,
  output logic       refund,
  output logic [1:0] product_id
);

  // Working width for credit arithmetic: two extra bits so that the largest
  // credit plus the largest single-cycle deposit (15) cannot wrap before the
  // saturation check.
  localparam int SUM_W = CREDIT_W + 2;

  localparam logic [CREDIT_W-1:0] C_CREDIT_MAX = {CREDIT_W{1'b1}};
  localparam logic [SUM_W-1:0]    C_CREDIT_MAX_EXT = {2'b00, C_CREDIT_MAX};
  localparam logic [SUM_W-1:0]    C_COIN_5_VAL  = SUM_W'(5);
  localparam logic [SUM_W-1:0]    C_COIN_10_VAL = SUM_W'(10);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;

  logic [SUM_W-1:0]    w_coin_value;
  logic [SUM_W-1:0]    w_credit_sum;
  logic [SUM_W-1:0]    w_credit_new;
  logic [SUM_W-1:0]    w_price;
  logic                w_price_met;
  logic                w_change_due;

  // Value deposited this cycle; both coins together contribute 15.
  always_comb begin
    w_coin_value = '0;
    if (coin_5) begin
      w_coin_value = w_coin_value + C_COIN_5_VAL;
    end
    if (coin_10) begin
      w_coin_value = w_coin_value + C_COIN_10_VAL;
    end
  end

  // Price of the latched product; 00 never reaches COLLECT so its price is moot.
  always_comb begin
    w_price = '0;
    case (product_id)
      2'b01:   w_price = SUM_W'(PRICE_1);
      2'b10:   w_price = SUM_W'(PRICE_2);
      2'b11:   w_price = SUM_W'(PRICE_3);
      default: w_price = '0;
    endcase
  end

  // Saturating credit update and the resulting vend / change decisions.
  always_comb begin
    w_credit_sum = {2'b00, r_credit} + w_coin_value;
    if (w_credit_sum > C_CREDIT_MAX_EXT) begin
      w_credit_new = C_CREDIT_MAX_EXT;
    end else begin
      w_credit_new = w_credit_sum;
    end
    w_price_met  = (w_credit_new >= w_price);
    w_change_due = (w_credit_new >  w_price);
  end

  // Transaction state machine; dispense/refund are registered alongside the
  // state so they are high exactly for the single VEND/RETURN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      product_id <= 2'b00;
      dispense   <= 1'b0;
      refund     <= 1'b0;
    end else begin
      dispense <= 1'b0;
      refund   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Coins and cancel are not accepted until a product is chosen.
          r_credit   <= '0;
          product_id <= 2'b00;
          if (select != 2'b00) begin
            product_id <= select;
            r_state    <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (cancel) begin
            // A coin arriving together with cancel is discarded.
            refund  <= (r_credit != '0);
            r_state <= ST_RETURN;
          end else begin
            r_credit <= w_credit_new[CREDIT_W-1:0];
            if (w_price_met) begin
              dispense <= 1'b1;
              refund   <= w_change_due;
              r_state  <= ST_VEND;
            end
          end
        end

        ST_VEND: begin
          r_credit   <= '0;
          product_id <= 2'b00;
          r_state    <= ST_IDLE;
        end

        ST_RETURN: begin
          r_credit   <= '0;
          product_id <= 2'b00;
          r_state    <= ST_IDLE;
        end

        default: begin
          r_credit   <= '0;
          product_id <= 2'b00;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vending_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_fsm
// Description : Directed self-checking bench for vending_fsm. Each step drives
//               one cycle of inputs and checks {dispense, refund, product_id}
//               one time unit after the sampling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_fsm;

  logic       clk;
  logic       rst;
  logic       coin_5;
  logic       coin_10;
  logic       cancel;
  logic [1:0] select;
  logic       dispense;
  logic       refund;
  logic [1:0] product_id;

  int checks;
  int errors;

  vending_fsm #(
    .PRICE_1  (15),
    .PRICE_2  (20),
    .PRICE_3  (25),
    .CREDIT_W (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_5     (coin_5),
    .coin_10    (coin_10),
    .cancel     (cancel),
    .select     (select),
    .dispense   (dispense),
    .refund     (refund),
    .product_id (product_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed {dispense, refund, product_id} with the expected value.
  task automatic check(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {dispense, refund, product_id};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed disp/ref/pid=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then clear them.
  task automatic step(input logic c5, input logic c10, input logic cn,
                      input logic [1:0] sel);
    coin_5  = c5;
    coin_10 = c10;
    cancel  = cn;
    select  = sel;
    @(posedge clk);
    #1;
    coin_5  = 1'b0;
    coin_10 = 1'b0;
    cancel  = 1'b0;
    select  = 2'b00;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    coin_5  = 1'b0;
    coin_10 = 1'b0;
    cancel  = 1'b0;
    select  = 2'b00;

    // Reset state
    #1;
    check("reset_async", 4'b0000);
    @(posedge clk);
    #1;
    check("reset_held", 4'b0000);
    rst = 1'b0;

    // IDLE ignores coins and cancel without a selection
    step(1'b0, 1'b1, 1'b0, 2'b00); check("idle_coin10", 4'b0000);
    step(1'b1, 1'b0, 1'b1, 2'b00); check("idle_coin5_cancel", 4'b0000);

    // Product 01 (15): 10 + 5 -> exact price, no change
    step(1'b0, 1'b0, 1'b0, 2'b01); check("p1_select", 4'b0001);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("p1_coin10", 4'b0001);
    step(1'b1, 1'b0, 1'b0, 2'b00); check("p1_vend", 4'b1001);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("p1_idle", 4'b0000);

    // Product 10: 10 then cancel -> refund only
    step(1'b0, 1'b0, 1'b0, 2'b10); check("p2c_select", 4'b0010);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("p2c_coin10", 4'b0010);
    step(1'b0, 1'b0, 1'b1, 2'b00); check("p2c_return", 4'b0110);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("p2c_idle", 4'b0000);

    // Product 11 (25): 10 x3 = 30 -> dispense with change
    step(1'b0, 1'b0, 1'b0, 2'b11); check("p3_select", 4'b0011);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("p3_coin10_a", 4'b0011);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("p3_coin10_b", 4'b0011);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("p3_vend_change", 4'b1111);
    // Inputs during VEND are ignored: select here must not start a new sale
    step(1'b0, 1'b0, 1'b0, 2'b01); check("p3_idle", 4'b0000);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("p3_still_idle", 4'b0000);

    // Product 10 (20): both coins (15), then 5 -> exact, no change
    step(1'b0, 1'b0, 1'b0, 2'b10); check("p2_select", 4'b0010);
    step(1'b1, 1'b1, 1'b0, 2'b00); check("p2_both_coins", 4'b0010);
    step(1'b1, 1'b0, 1'b0, 2'b00); check("p2_vend", 4'b1010);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("p2_idle", 4'b0000);

    // Select ignored in COLLECT; cancel with zero credit -> no refund
    step(1'b0, 1'b0, 1'b0, 2'b01); check("z_select", 4'b0001);
    step(1'b0, 1'b0, 1'b0, 2'b11); check("z_reselect", 4'b0001);
    step(1'b0, 1'b0, 1'b1, 2'b00); check("z_return", 4'b0001);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("z_idle", 4'b0000);

    // Product 01: 10, then cancel+coin5 -> coin discarded, refund
    step(1'b0, 1'b0, 1'b0, 2'b01); check("cc_select", 4'b0001);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("cc_coin10", 4'b0001);
    step(1'b1, 1'b0, 1'b1, 2'b00); check("cc_return", 4'b0101);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("cc_idle", 4'b0000);

    // Reset mid-COLLECT: immediate IDLE, credit lost, no pulses afterwards
    step(1'b0, 1'b0, 1'b0, 2'b01); check("rst_select", 4'b0001);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("rst_coin10", 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_mid", 4'b0000);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 2'b00); check("rst_coin5_after", 4'b0000);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("rst_quiet", 4'b0000);

    // Credit really was lost: a fresh sale of 01 needs the full 15
    step(1'b0, 1'b0, 1'b0, 2'b01); check("post_select", 4'b0001);
    step(1'b1, 1'b0, 1'b0, 2'b00); check("post_coin5", 4'b0001);
    step(1'b0, 1'b1, 1'b0, 2'b00); check("post_vend", 4'b1001);
    step(1'b0, 1'b0, 1'b0, 2'b00); check("post_idle", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
